// File: rtl/multicycle_adder_pkg.sv
// Shared types and sizing helpers for the chunked multicycle adder.
// Optional overflow output is enabled with MULTICYCLE_ADDER_OVF_EN.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int nchunk(input int nb, input int ch);
    return (ch < 1) ? 1 : nb / ch;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder.
// overflow exists only when MULTICYCLE_ADDER_OVF_EN is defined.
interface multicycle_adder_if #(
  parameter int NUMBITS = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [NUMBITS-1:0] A;
  logic [NUMBITS-1:0] B;
  logic               carryin;
  logic               sub;
  logic               out_valid;
  logic               out_ready;
  logic [NUMBITS-1:0] result;
  logic               carryout;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic               overflow;

  modport master (
    output in_valid, A, B, carryin, sub, out_ready,
    input  in_ready, out_valid, result, carryout, overflow
  );
  modport slave (
    input  in_valid, A, B, carryin, sub, out_ready,
    output in_ready, out_valid, result, carryout, overflow
  );
`else
  modport master (
    output in_valid, A, B, carryin, sub, out_ready,
    input  in_ready, out_valid, result, carryout
  );
  modport slave (
    input  in_valid, A, B, carryin, sub, out_ready,
    output in_ready, out_valid, result, carryout
  );
`endif
endinterface

// File: rtl/multicycle_adder_rca.sv
// Combinational ripple-carry adder used as the per-chunk adder.
// No configuration macros.
module ripple_carry_adder #(
  parameter int NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               carryin,
  output logic [NUMBITS-1:0] result,
  output logic               carryout
);
  logic [NUMBITS:0] c;

  always_comb begin
    c      = '0;
    result = '0;
    c[0]   = carryin;
    for (int i = 0; i < NUMBITS; i++) begin
      result[i] = A[i] ^ B[i] ^ c[i];
      c[i+1]    = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    carryout = c[NUMBITS];
  end
endmodule

// File: rtl/multicycle_adder.sv
// Add/subtract CHUNK bits per cycle through a registered carry.
// Define MULTICYCLE_ADDER_OVF_EN to add the signed overflow output.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int NUMBITS = 32,
  parameter int CHUNK   = 8
) (
  input logic              clk,
  input logic              reset,
  multicycle_adder_if.slave bus
);
  localparam int CHK    = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK = nchunk(NUMBITS, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > NUMBITS || (NUMBITS % CHK) != 0)
  begin : g_bad_cfg
    $error("multicycle_adder: NUMBITS must be a multiple of CHUNK");
  end

  state_e             state_q;
  logic [NUMBITS-1:0] a_q;
  logic [NUMBITS-1:0] b_q;
  logic [NUMBITS-1:0] res_q;
  logic [CW-1:0]      k_q;
  logic               cy_q;
  logic               co_q;
  logic               vld_q;
  logic               rdy_q;

  logic [CHUNK-1:0]   ch_a;
  logic [CHUNK-1:0]   ch_b;
  logic [CHUNK-1:0]   ch_s;
  logic               ch_c;

  assign ch_a = a_q[int'(k_q)*CHUNK +: CHUNK];
  assign ch_b = b_q[int'(k_q)*CHUNK +: CHUNK];

  ripple_carry_adder #(
    .NUMBITS (CHUNK)
  ) u_rca (
    .A        (ch_a),
    .B        (ch_b),
    .carryin  (cy_q),
    .result   (ch_s),
    .carryout (ch_c)
  );

`ifdef MULTICYCLE_ADDER_OVF_EN
  logic ovf_q;
  logic ch_ov;
  // carry into the MSB is recovered from the MSB sum bit
  assign ch_ov = ch_a[CHUNK-1] ^ ch_b[CHUNK-1]
               ^ ch_s[CHUNK-1] ^ ch_c;
  assign bus.overflow = ovf_q;
`endif

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.result    = res_q;
  assign bus.carryout  = co_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b1;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            b_q     <= bus.B ^ {NUMBITS{bus.sub}};
            cy_q    <= bus.sub ? 1'b1 : bus.carryin;
            res_q   <= '0;
            k_q     <= '0;
            rdy_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q[int'(k_q)*CHUNK +: CHUNK] <= ch_s;
          cy_q <= ch_c;
          k_q  <= k_q + 1'b1;
          if (k_q == LAST) begin
            co_q    <= ch_c;
            vld_q   <= 1'b1;
            state_q <= DONE;
`ifdef MULTICYCLE_ADDER_OVF_EN
            ovf_q   <= ch_ov;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench: directed cases on several widths plus
// randomized ops against an arithmetic reference model.
module tb_multicycle_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_adder_if #(.NUMBITS(8))   i8   ();
  multicycle_adder_if #(.NUMBITS(32))  i32  ();
  multicycle_adder_if #(.NUMBITS(64))  i64  ();
  multicycle_adder_if #(.NUMBITS(128)) i128 ();

  multicycle_adder #(.NUMBITS(8), .CHUNK(8)) u8 (
    .clk(clk), .reset(rst_n), .bus(i8.slave));
  multicycle_adder #(.NUMBITS(32), .CHUNK(8)) u32 (
    .clk(clk), .reset(rst_n), .bus(i32.slave));
  multicycle_adder #(.NUMBITS(64), .CHUNK(4)) u64 (
    .clk(clk), .reset(rst_n), .bus(i64.slave));
  multicycle_adder #(.NUMBITS(128), .CHUNK(16)) u128 (
    .clk(clk), .reset(rst_n), .bus(i128.slave));

  task automatic idle_inputs();
    i8.in_valid = 0;   i8.out_ready = 0;
    i8.A = '0; i8.B = '0; i8.carryin = 0; i8.sub = 0;
    i32.in_valid = 0;  i32.out_ready = 0;
    i32.A = '0; i32.B = '0; i32.carryin = 0; i32.sub = 0;
    i64.in_valid = 0;  i64.out_ready = 0;
    i64.A = '0; i64.B = '0; i64.carryin = 0; i64.sub = 0;
    i128.in_valid = 0; i128.out_ready = 0;
    i128.A = '0; i128.B = '0; i128.carryin = 0; i128.sub = 0;
  endtask

  // Present one op on the 32-bit DUT, scramble inputs after accept,
  // and count negedges until out_valid.
  task automatic op32(input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic s, output int lat);
    @(negedge clk);
    i32.A = a; i32.B = b; i32.carryin = ci; i32.sub = s;
    i32.in_valid = 1;
    @(negedge clk);
    i32.in_valid = 0;
    i32.A = $urandom(); i32.B = $urandom();
    i32.carryin = 1'($urandom()); i32.sub = 1'($urandom());
    lat = 0;
    while (!i32.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release32();
    i32.out_ready = 1;
    @(negedge clk);
    i32.out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (i32.in_ready !== 1'b1 || i32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: rdy=%b vld=%b want 1/0",
               i32.in_ready, i32.out_valid);
    end
    checks++;
    if (i32.result !== 32'h0 || i32.carryout !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: res=%h co=%b want 0/0",
               i32.result, i32.carryout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (i64.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy64: got %b want 1", i64.in_ready);
    end
  endtask

  task automatic test_single_chunk();
    int lat;
    @(negedge clk);
    i8.A = 8'hFF; i8.B = 8'h01; i8.carryin = 0; i8.sub = 0;
    i8.in_valid = 1;
    @(negedge clk);
    i8.in_valid = 0;
    lat = 0;
    while (!i8.out_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL lat8: got %0d want 1", lat);
    end
    checks++;
    if (i8.result !== 8'h00 || i8.carryout !== 1'b1) begin
      errors++;
      $display("FAIL add8: res=%h co=%b want 00/1",
               i8.result, i8.carryout);
    end
    i8.out_ready = 1;
    @(negedge clk);
    i8.out_ready = 0;
  endtask

  task automatic test_carry_chain();
    int lat;
    op32(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL lat32: got %0d want 4", lat);
    end
    checks++;
    if (i32.result !== 32'h0 || i32.carryout !== 1'b1) begin
      errors++;
      $display("FAIL chain32: res=%h co=%b want 0/1",
               i32.result, i32.carryout);
    end
    release32();
  endtask

  task automatic test_sub_overflow();
    int lat;
    // carryin=1 must be ignored in subtract mode
    op32(32'd5, 32'd7, 1'b1, 1'b1, lat);
    checks++;
    if (i32.result !== 32'hFFFFFFFE || i32.carryout !== 1'b0) begin
      errors++;
      $display("FAIL sub5_7: res=%h co=%b want fffffffe/0",
               i32.result, i32.carryout);
    end
`ifdef MULTICYCLE_ADDER_OVF_EN
    checks++;
    if (i32.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sub: got %b want 0", i32.overflow);
    end
`endif
    release32();
    op32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, lat);
    checks++;
    if (i32.result !== 32'h80000000 || i32.carryout !== 1'b0) begin
      errors++;
      $display("FAIL add_max: res=%h co=%b want 80000000/0",
               i32.result, i32.carryout);
    end
`ifdef MULTICYCLE_ADDER_OVF_EN
    checks++;
    if (i32.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_add: got %b want 1", i32.overflow);
    end
`endif
    release32();
    op32(32'h0, 32'h0, 1'b0, 1'b1, lat);
    checks++;
    if (i32.result !== 32'h0 || i32.carryout !== 1'b1) begin
      errors++;
      $display("FAIL sub0_0: res=%h co=%b want 0/1",
               i32.result, i32.carryout);
    end
    release32();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] a, b;
    logic [32:0] exp;
    a = $urandom();
    b = $urandom();
    exp = {1'b0, a} + {1'b0, b} + 33'd1;
    op32(a, b, 1'b1, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      i32.A = $urandom(); i32.B = $urandom(); i32.in_valid = 1;
      @(negedge clk);
      checks++;
      if ({i32.carryout, i32.result} !== exp || i32.in_ready !== 1'b0
          || i32.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold%0d: got %h rdy=%b vld=%b want %h 0 1",
                 i, {i32.carryout, i32.result}, i32.in_ready,
                 i32.out_valid, exp);
      end
    end
    i32.out_ready = 1;
    @(negedge clk);
    i32.out_ready = 0;
    i32.in_valid = 0;
    checks++;
    if (i32.in_ready !== 1'b1 || i32.out_valid !== 1'b0
        || {i32.carryout, i32.result} !== exp) begin
      errors++;
      $display("FAIL handoff: rdy=%b vld=%b got %h want 1 0 %h",
               i32.in_ready, i32.out_valid,
               {i32.carryout, i32.result}, exp);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    // park the 32-bit DUT in DONE with a nonzero result
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, lat);
    @(negedge clk);
    i128.A = '1; i128.B = 128'h1; i128.carryin = 0; i128.sub = 0;
    i128.in_valid = 1;
    @(negedge clk);
    i128.in_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (i128.out_valid !== 1'b0 || i128.result !== 128'h0
        || i128.carryout !== 1'b0 || i128.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst128: vld=%b res=%h co=%b rdy=%b",
               i128.out_valid, i128.result, i128.carryout,
               i128.in_ready);
    end
    checks++;
    if (i32.out_valid !== 1'b0 || i32.result !== 32'h0
        || i32.carryout !== 1'b0) begin
      errors++;
      $display("FAIL rst_done: vld=%b res=%h co=%b want 0 0 0",
               i32.out_valid, i32.result, i32.carryout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i128.A = 128'h1; i128.B = 128'h1; i128.in_valid = 1;
    @(negedge clk);
    i128.in_valid = 0;
    lat = 0;
    while (!i128.out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 8 || i128.result !== 128'h2 || i128.carryout !== 1'b0)
    begin
      errors++;
      $display("FAIL after_rst: lat=%0d res=%h co=%b want 8 2 0",
               lat, i128.result, i128.carryout);
    end
    i128.out_ready = 1;
    @(negedge clk);
    i128.out_ready = 0;
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic        s, ci;
    logic [64:0] exp;
    int          lat, stall;
    for (int n = 0; n < 1000; n++) begin
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      s  = 1'($urandom());
      ci = 1'($urandom());
      if (s) exp = {a >= b, a - b};
      else   exp = {1'b0, a} + {1'b0, b} + {64'd0, ci};
      i64.A = a; i64.B = b; i64.sub = s; i64.carryin = ci;
      i64.in_valid = 1;
      @(negedge clk);
      i64.in_valid = 0;
      lat = 0;
      while (!i64.out_valid && lat < 64) begin
        i64.out_ready = 1'($urandom());
        i64.A = {$urandom(), $urandom()};
        @(negedge clk);
        lat++;
      end
      i64.out_ready = 0;
      checks++;
      if (lat != 16) begin
        errors++;
        $display("FAIL rnd_lat%0d: got %0d want 16", n, lat);
      end
      checks++;
      if ({i64.carryout, i64.result} !== exp) begin
        errors++;
        $display("FAIL rnd%0d: got %h want %h", n,
                 {i64.carryout, i64.result}, exp);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      i64.out_ready = 1;
      @(negedge clk);
      i64.out_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_single_chunk();
    test_carry_chain();
    test_sub_overflow();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
